// File: rtl/gather_if.sv
// Handshake bundle for the two-lane gather: two worker-side streams in,
// one tagged upstream stream out.
interface gather_if #(
  parameter int width = 160
);
  logic [width-1:0] s0_data;
  logic             s0_valid;
  logic             s0_ready;
  logic [width-1:0] s1_data;
  logic             s1_valid;
  logic             s1_ready;
  logic [width-1:0] m_data;
  logic             m_id;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output s0_data, s0_valid, s1_data, s1_valid, m_ready,
    input  s0_ready, s1_ready, m_data, m_id, m_valid
  );

  modport slave (
    input  s0_data, s0_valid, s1_data, s1_valid, m_ready,
    output s0_ready, s1_ready, m_data, m_id, m_valid
  );
endinterface

// File: rtl/gather.sv
// Round-robin two-to-one merge into a small FIFO; each stored word carries
// its source lane in the top bit so upstream can attribute results.
module gather #(
  parameter int width = 160,
  parameter int depth = 2
) (
  input  logic    clock,
  input  logic    reset,
  gather_if.slave bus
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [width:0]  mem_r [depth];
  logic [aw-1:0]   rd_r;
  logic [aw-1:0]   wr_r;
  logic [cw-1:0]   count_r;
  logic            last_r;

  logic            full_s;
  logic            empty_s;
  logic            grant_valid_s;
  logic            grant_lane_s;
  logic            pop_s;

  assign full_s  = (count_r == cw'(depth));
  assign empty_s = (count_r == cw'(0));
  assign pop_s   = !empty_s && bus.m_ready;

  // Arbitration: a tie goes to the lane that was not granted last; nothing is granted while full.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_lane_s  = 1'b0;
    if (full_s) begin
      grant_valid_s = 1'b0;
      grant_lane_s  = 1'b0;
    end else begin
      case ({bus.s1_valid, bus.s0_valid})
        2'b01: begin
          grant_valid_s = 1'b1;
          grant_lane_s  = 1'b0;
        end
        2'b10: begin
          grant_valid_s = 1'b1;
          grant_lane_s  = 1'b1;
        end
        2'b11: begin
          grant_valid_s = 1'b1;
          grant_lane_s  = !last_r;
        end
        default: begin
          grant_valid_s = 1'b0;
          grant_lane_s  = 1'b0;
        end
      endcase
    end
  end

  assign bus.s0_ready = grant_valid_s && !grant_lane_s;
  assign bus.s1_ready = grant_valid_s && grant_lane_s;

  // Head of the FIFO is driven straight from storage; no bypass from the inputs.
  assign bus.m_valid = !empty_s;
  assign bus.m_data  = mem_r[rd_r][width-1:0];
  assign bus.m_id    = mem_r[rd_r][width];

  // FIFO storage, pointers, occupancy and round-robin state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= '0;
      end
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
      last_r  <= 1'b1;
    end else begin
      if (grant_valid_s) begin
        mem_r[wr_r] <= grant_lane_s ? {1'b1, bus.s1_data} : {1'b0, bus.s0_data};
        wr_r        <= wr_r + aw'(1);
        last_r      <= grant_lane_s;
      end
      if (pop_s) begin
        rd_r <= rd_r + aw'(1);
      end
      case ({grant_valid_s, pop_s})
        2'b10:   count_r <= count_r + cw'(1);
        2'b01:   count_r <= count_r - cw'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_gather.sv
// Self-checking bench for gather: an independent model of grant and FIFO
// contents predicts readys and the exact order of words leaving upstream.
module tb_gather;
  localparam int width = 160;

  logic clock;
  logic reset;

  gather_if #(.width(width)) bus ();

  gather #(.width(width), .depth(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [width:0] mq[$];
  logic           mlast = 1'b1;
  logic           acc0;
  logic           acc1;

  task automatic check_val(input string tag, input logic [width:0] got, input logic [width:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    logic g_valid;
    logic g_lane;
    logic pop_m;
    @(negedge clock);
    g_valid = 1'b0;
    g_lane  = 1'b0;
    if (mq.size() < 2) begin
      if (bus.s0_valid && !bus.s1_valid) begin
        g_valid = 1'b1; g_lane = 1'b0;
      end else if (!bus.s0_valid && bus.s1_valid) begin
        g_valid = 1'b1; g_lane = 1'b1;
      end else if (bus.s0_valid && bus.s1_valid) begin
        g_valid = 1'b1; g_lane = !mlast;
      end
    end
    check_val("s0_ready", {160'd0, bus.s0_ready}, {160'd0, g_valid && !g_lane});
    check_val("s1_ready", {160'd0, bus.s1_ready}, {160'd0, g_valid && g_lane});
    check_val("m_valid", {160'd0, bus.m_valid}, {160'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check_val("m_data", {1'b0, bus.m_data}, {1'b0, mq[0][width-1:0]});
      check_val("m_id", {160'd0, bus.m_id}, {160'd0, mq[0][width]});
    end
    pop_m = (mq.size() != 0) && bus.m_ready;
    @(posedge clock);
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!reset) begin
      mq.delete();
      mlast = 1'b1;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (g_valid) begin
        mq.push_back(g_lane ? {1'b1, bus.s1_data} : {1'b0, bus.s0_data});
        mlast = g_lane;
        if (g_lane) begin
          acc1 = 1'b1;
          bus.s1_data = bus.s1_data + 160'd1;
        end else begin
          acc0 = 1'b0 | 1'b1;
          bus.s0_data = bus.s0_data + 160'd1;
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b1;
  endtask

  initial begin
    int words;
    reset        = 1'b0;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.s0_data  = 160'hA0;
    bus.s1_data  = 160'hB0;
    bus.m_ready  = 1'b0;
    acc0 = 1'b0;
    acc1 = 1'b0;

    // Reset hold and release with no traffic.
    do_reset(3);
    step();
    check_val("rst_m_data", {1'b0, bus.m_data}, 161'd0);
    check_val("rst_m_id", {160'd0, bus.m_id}, 161'd0);
    bus.s0_valid = 1'b1;
    step();
    bus.s0_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Both lanes streaming, upstream always ready: strict alternation from lane 0.
    bus.m_ready = 1'b0;
    do_reset(1);
    bus.s0_data  = 160'hA0;
    bus.s1_data  = 160'hB0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Lane 1 fills the FIFO while upstream stalls, then drains.
    bus.m_ready  = 1'b0;
    bus.s1_data  = 160'h11;
    bus.s1_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.m_ready = 1'b1;
    bus.s1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Full FIFO with a pop and a pending lane-0 word in the same cycle.
    bus.m_ready  = 1'b0;
    bus.s0_data  = 160'h50;
    bus.s0_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.s0_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Lane 1 alone for five words after reset, then both lanes.
    bus.m_ready = 1'b0;
    do_reset(1);
    bus.m_ready  = 1'b1;
    bus.s1_data  = 160'hC0;
    bus.s0_data  = 160'hD0;
    bus.s1_valid = 1'b1;
    words = 0;
    for (int i = 0; i < 20 && words < 5; i++) begin
      step();
      if (acc1) words++;
    end
    bus.s0_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Random mix: sources hold valid until accepted, upstream ready is random.
    words = 0;
    for (int i = 0; i < 300 && words < 20; i++) begin
      if (acc0 || !bus.s0_valid) bus.s0_valid = 1'($urandom_range(0, 1));
      if (acc1 || !bus.s1_valid) bus.s1_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
      if (acc0 || acc1) words++;
    end
    check_val("random_words", 161'(words), 161'd20);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset with two buffered words discards them.
    bus.m_ready  = 1'b0;
    bus.s0_data  = 160'hE0;
    bus.s0_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.s0_valid = 1'b0;
    do_reset(1);
    step();
    check_val("post_rst_m_data", {1'b0, bus.m_data}, 161'd0);
    check_val("post_rst_m_id", {160'd0, bus.m_id}, 161'd0);
    bus.s1_data  = 160'hF0;
    bus.s1_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.s1_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/gather.md
Name: gather

Overview:
- Two-to-one merge that collects result words from two worker lanes and presents them on a single upstream stream. It is the return-path counterpart of the one-to-two distributor.
- Arbitrates fairly (round-robin) between lanes and buffers accepted words in a small FIFO.
- Tags each word with its source lane so upstream can attribute results.

Parameters:
- width, 160, payload width in bits of every data port.
- depth, 2, FIFO entries; power of two, ≥ 2.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- s0_data  input  width  lane 0 payload.
- s0_valid  input  1  lane 0 word available.
- s0_ready  output  1  lane 0 word accepted this cycle when high together with s0_valid.
- s1_data  input  width  lane 1 payload.
- s1_valid  input  1  lane 1 word available.
- s1_ready  output  1  lane 1 accept, same rule as lane 0.
- m_data  output  width  FIFO head payload.
- m_id  output  1  source lane of head word (0 or 1).
- m_valid  output  1  head word present.
- m_ready  input  1  upstream accepts head.

Behaviour:
- Handshake: a transfer occurs on an edge where valid && ready are both high. Once asserted, valid/data must stay stable until the transfer; the block obeys this on m_*. Ready may depend on valid; valid never depends on ready.
- State:
  - FIFO storage: depth entries of width+1 bits.
  - Read pointer rd and write pointer wr: log2(depth) bits, wrap modulo depth.
  - Occupancy count: 0..depth.
  - Round-robin pointer last: 1 bit, lane most recently granted.
- full = (count == depth); empty = (count == 0).
- Grant (combinational), computed only when !full:
  - only s0_valid: grant 0.
  - only s1_valid: grant 1.
  - both valid: grant !last.
  - neither valid: no grant.
- s0_ready = !full && grant==0 && s0_valid; s1_ready likewise. When full, both readys are 0. At most one lane is accepted per cycle.
- Push: on accepted transfer, write {lane, data} at wr, wr <= wr+1, last <= lane. last changes only on an accepted push.
- Pop: m_valid = !empty; m_data/m_id = entry[rd]. On m_valid && m_ready: rd <= rd+1.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, no push is possible even if a pop occurs the same cycle (no combinational m_ready→s_ready path).
- No bypass: a word accepted at edge N is visible on m_* from cycle N+1 at the earliest. Minimum latency 1 cycle.
- Throughput: one word per cycle sustained when m_ready stays high.
- Ordering: FIFO order equals acceptance order; no reordering or dropping.
- Reset (reset==0 at an edge), including mid-transfer:
  - count=0, rd=0, wr=0, last=1 (lane 0 wins the first tie), all storage cleared to 0.
  - Outputs after reset: m_valid=0, m_data=0, m_id=0.
  - s0_ready/s1_ready follow the grant rule from the first cycle out of reset.
  - Buffered words are discarded.
- Pointer wrap: rd/wr wrap from depth-1 to 0 with no bubble.

Test Plan:
- Reset hold then release, no valids → m_valid=0, m_data=0, m_id=0, s0_ready=s1_ready=0; raise s0_valid only → s0_ready=1 that cycle.
- Both lanes continuously valid (s0 words 0xA0.., s1 words 0xB0..), m_ready=1 → output alternates id 0,1,0,1 starting with lane 0 (0xA0, 0xB0, 0xA1, …), one word per cycle after 1-cycle latency.
- m_ready=0, s1 pushes 0x11, 0x12 (depth=2) → after 2 accepts s1_ready=0; raise m_ready → 0x11 then 0x12 with m_id=1; s1_ready returns 1 the cycle after the first pop.
- Full FIFO with m_ready=1 and s0_valid=1 on the same cycle → pop happens, no push that cycle; push accepted the next cycle; count never exceeds 2.
- Only s1 valid for 5 words then both valid → the first tie goes to lane 0 (last=1); no lane starves; the 20-word mixed random run matches the scoreboard order exactly.
- Reset asserted with 2 words buffered and m_valid=1 → next cycle m_valid=0, count 0; subsequent pushes emerge correctly from pointer 0.
